uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
Parametrised UART receive controller. It recovers one asynchronous serial frame at a time from RXD, using a baud×OVERSAMPLE tick strobe. Each frame is start, DATA_BITS data bits LSB first, optional parity, then STOP_BITS stop bits. The block sits between the RX line and the RX FIFO/host. It presents each byte on a valid/ready handshake with per-frame frame, parity and overrun status.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
OVERSAMPLE, 16, TICK pulses per bit period (even, 8..32)
PARITY_EN, 0, 1 = parity bit present after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits checked (1 or 2)

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  synchronous reset, active-high
TICK  in  1  single-cycle strobe at baud×OVERSAMPLE
RXD  in  1  asynchronous serial input, idle high
RX_DATA  out  DATA_BITS  received data word
RX_VALID  out  1  RX_DATA and status flags valid
RX_READY  in  1  consumer accepts when RX_VALID&RX_READY
FRAME_ERROR  out  1  a stop bit sampled low for this word; qualified by RX_VALID
PARITY_ERROR  out  1  parity mismatch for this word; qualified by RX_VALID
OVERRUN  out  1  at least one frame dropped while RX_VALID was held
RXRDY  out  1  1 when receiver is idle (state IDLE)

Behaviour:
- Reset (synchronous, RST=1 at a CLK edge):
  - Synchronizer flops set to 1.
  - State IDLE, armed=0, tick counter 0, bit counter 0.
  - RX_DATA=0, RX_VALID=0, FRAME_ERROR=0, PARITY_ERROR=0, OVERRUN=0, RXRDY=1.
  - Reset mid-frame aborts the frame; no output is produced for it.
- RXD passes through a 2-flop synchronizer (rxd_s). All decisions use rxd_s and advance only on cycles with TICK=1.
- IDLE:
  - armed is set when rxd_s=1. This requires the line to be seen high before each start, so a break or stuck-low line cannot retrigger.
  - When armed and rxd_s=0: go to START, clear the tick counter, RXRDY=0.
- START: count OVERSAMPLE/2 ticks to reach mid-bit, then sample.
  - rxd_s=0: go to DATA, clear the counters.
  - rxd_s=1: false start; go to IDLE with no output and no flags.
- DATA: sample every OVERSAMPLE ticks.
  - Each sample shifts in at the MSB and shifts right, so bit 0 is first on the wire.
  - After DATA_BITS samples: go to PARITY if PARITY_EN, else STOP.
- PARITY: sample after OVERSAMPLE ticks.
  - perr = sampled bit XOR (XOR-reduce data) XOR PARITY_ODD.
  - perr is forced to 0 when PARITY_EN=0.
- STOP: sample STOP_BITS times, OVERSAMPLE ticks apart. ferr = OR of (stop sample == 0).
  - After the last stop sample, go to IDLE with armed=rxd_s.
- Frame completion, in the CLK cycle after the final stop sample:
  - If RX_VALID=0, or RX_VALID&RX_READY in that same cycle: load RX_DATA, FRAME_ERROR=ferr, PARITY_ERROR=perr. RX_VALID=1 and OVERRUN=0.
  - Otherwise the new frame is discarded. The held RX_DATA and flags are unchanged, and OVERRUN is set to 1.
  - The frame is delivered even when ferr or perr is set.
- Handshake:
  - RX_DATA and the flags are held stable while RX_VALID=1 and RX_READY=0.
  - Acceptance with no simultaneous completion: RX_VALID=0 and OVERRUN=0 on the next cycle.
  - RX_READY is ignored while RX_VALID=0.
- Latency: RX_VALID rises 1 CLK after the TICK on which the last stop bit is sampled, i.e. at mid-stop-bit.
- Counter widths:
  - Tick counter: $clog2(OVERSAMPLE).
  - Bit counter: $clog2(DATA_BITS+1).
  - Both wrap/clear explicitly on every state change.
- TICK=0 freezes all state except the synchronizer, the armed flag and the handshake logic.

Test Plan:
- 8N1, OVERSAMPLE=16, send 0xA5 with RX_READY=1 → RX_VALID pulses 1 cycle, RX_DATA=0xA5, all flags 0, RXRDY returns to 1.
- PARITY_EN=1, PARITY_ODD=0, send 0x03 with parity bit 1 (wrong) → RX_DATA=0x03, PARITY_ERROR=1. Repeat with parity bit 0 → PARITY_ERROR=0.
- STOP_BITS=2, send 0x5A with second stop bit low, then line held low for 3 frame times → one word, 0x5A with FRAME_ERROR=1. No further RX_VALID until the line returns high and a new start arrives.
- RX_READY=0, send 0x11 then 0x22 → RX_DATA stays 0x11 and OVERRUN=1. Raise RX_READY for 1 cycle → RX_VALID=0, OVERRUN=0.
- Low glitch of 4 ticks on RXD in IDLE → false start, back to IDLE, no RX_VALID. A following 0x7E frame is received correctly.
- Assert RST in DATA after 3 bits of 0xFF → all outputs at reset values next cycle. The following 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_frame_ctrl_if.sv
// Receive-side handshake bundle of uart_rx_frame_ctrl.
//   RX_DATA      : received data word
//   RX_VALID     : RX_DATA and status flags valid
//   RX_READY     : consumer accepts when RX_VALID & RX_READY
//   FRAME_ERROR  : stop bit sampled low for this word
//   PARITY_ERROR : parity mismatch for this word
//   OVERRUN      : at least one frame dropped while RX_VALID was held
// master = receiver (drives data/flags), slave = consumer (drives RX_READY).
interface uart_rx_frame_ctrl_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] RX_DATA;
  logic                 RX_VALID;
  logic                 RX_READY;
  logic                 FRAME_ERROR;
  logic                 PARITY_ERROR;
  logic                 OVERRUN;

  modport master (
    output RX_DATA, RX_VALID, FRAME_ERROR, PARITY_ERROR, OVERRUN,
    input  RX_READY
  );

  modport slave (
    input  RX_DATA, RX_VALID, FRAME_ERROR, PARITY_ERROR, OVERRUN,
    output RX_READY
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive controller: recovers one serial frame at a time from RXD using
// a baud x OVERSAMPLE tick strobe and presents each word on a valid/ready
// handshake with frame, parity and overrun status.
//   CLK   : system clock, rising edge
//   RST   : synchronous reset, active-high
//   TICK  : single-cycle strobe at baud x OVERSAMPLE
//   RXD   : asynchronous serial input, idle high
//   RXRDY : 1 while the receiver is idle
//   rx_if : data/status handshake (master side)
module uart_rx_frame_ctrl #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TICK,
  input  logic                  RXD,
  output logic                  RXRDY,
  uart_rx_frame_ctrl_if.master  rx_if
);

  localparam int unsigned TCW = $clog2(OVERSAMPLE);
  localparam int unsigned BCW = $clog2(DATA_BITS + 1);

  localparam logic [TCW-1:0] HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] FULL_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
  localparam logic           PAR_EN    = (PARITY_EN != 0);
  localparam logic           PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q,      state_d;
  logic                 rxd_meta_q,   rxd_meta_d;
  logic                 rxd_s_q,      rxd_s_d;
  logic                 armed_q,      armed_d;
  logic [TCW-1:0]       tick_cnt_q,   tick_cnt_d;
  logic [BCW-1:0]       bit_cnt_q,    bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,      shift_d;
  logic                 perr_q,       perr_d;
  logic                 ferr_q,       ferr_d;
  logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
  logic                 rx_valid_q,   rx_valid_d;
  logic                 frame_err_q,  frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q,    overrun_d;
  logic                 rxrdy_q,      rxrdy_d;

  logic                 done_c;
  logic                 ferr_fin_c;
  logic                 bit_end_c;

  // Next-state, datapath and handshake logic.
  always_comb begin
    state_d      = state_q;
    rxd_meta_d   = RXD;
    rxd_s_d      = rxd_meta_q;
    armed_d      = armed_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;
    done_c       = 1'b0;
    ferr_fin_c   = ferr_q;
    bit_end_c    = (tick_cnt_q == FULL_LAST);

    case (state_q)
      S_IDLE: begin
        // Line must be seen high before a start is accepted (break lockout).
        if (rxd_s_q) begin
          armed_d = 1'b1;
        end
        if (TICK && armed_q && !rxd_s_q) begin
          state_d    = S_START;
          armed_d    = 1'b0;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end

      S_START: begin
        if (TICK) begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            if (rxd_s_q) begin
              state_d = S_IDLE;
              armed_d = 1'b1;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end

      S_DATA: begin
        if (TICK) begin
          if (bit_end_c) begin
            tick_cnt_d = '0;
            // LSB arrives first: shift in at the top, shift right.
            shift_d    = {rxd_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = '0;
              state_d   = PAR_EN ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end

      S_PARITY: begin
        if (TICK) begin
          if (bit_end_c) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = S_STOP;
            perr_d     = PAR_EN & (rxd_s_q ^ (^shift_q) ^ PAR_ODD);
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end

      S_STOP: begin
        if (TICK) begin
          if (bit_end_c) begin
            tick_cnt_d = '0;
            ferr_fin_c = ferr_q | ~rxd_s_q;
            ferr_d     = ferr_fin_c;
            if (bit_cnt_q == STOP_LAST) begin
              bit_cnt_d = '0;
              state_d   = S_IDLE;
              armed_d   = rxd_s_q;
              done_c    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end

      default: begin
        state_d    = S_IDLE;
        armed_d    = 1'b0;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase

    // Completion either lands in a free/draining slot or is dropped as overrun.
    if (done_c) begin
      if (!rx_valid_q || rx_if.RX_READY) begin
        rx_data_d    = shift_d;
        frame_err_d  = ferr_fin_c;
        parity_err_d = perr_q;
        rx_valid_d   = 1'b1;
        overrun_d    = 1'b0;
      end else begin
        overrun_d    = 1'b1;
      end
    end else if (rx_valid_q && rx_if.RX_READY) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    rxrdy_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      rxd_meta_q   <= 1'b1;
      rxd_s_q      <= 1'b1;
      armed_q      <= 1'b0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      rxrdy_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      rxd_meta_q   <= rxd_meta_d;
      rxd_s_q      <= rxd_s_d;
      armed_q      <= armed_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      rxrdy_q      <= rxrdy_d;
    end
  end

  assign rx_if.RX_DATA      = rx_data_q;
  assign rx_if.RX_VALID     = rx_valid_q;
  assign rx_if.FRAME_ERROR  = frame_err_q;
  assign rx_if.PARITY_ERROR = parity_err_q;
  assign rx_if.OVERRUN      = overrun_q;
  assign RXRDY              = rxrdy_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: an 8N1 receiver (A) and an 8E2
// receiver (B) share clock, tick and reset; each has its own serial line.
module tb_uart_rx_frame_ctrl;

  logic clk;
  logic rst;
  logic tick;
  logic rxd_a;
  logic rxd_b;
  logic rxrdy_a;
  logic rxrdy_b;
  logic mid_rxrdy;

  int n_err    = 0;
  int n_checks = 0;
  int vcnt_a   = 0;
  int vcnt_b   = 0;
  int base;

  uart_rx_frame_ctrl_if #(.DATA_BITS(8)) ifa ();
  uart_rx_frame_ctrl_if #(.DATA_BITS(8)) ifb ();

  uart_rx_frame_ctrl #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_a (
    .CLK(clk), .RST(rst), .TICK(tick), .RXD(rxd_a), .RXRDY(rxrdy_a), .rx_if(ifa)
  );

  uart_rx_frame_ctrl #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
  ) dut_b (
    .CLK(clk), .RST(rst), .TICK(tick), .RXD(rxd_b), .RXRDY(rxrdy_b), .rx_if(ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One tick every 4 clocks.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  // Count cycles with RX_VALID high, sampled on the falling edge.
  always @(negedge clk) begin
    if (ifa.RX_VALID === 1'b1) vcnt_a++;
    if (ifb.RX_VALID === 1'b1) vcnt_b++;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive_line(input int line, input logic v);
    if (line == 0) rxd_a = v;
    else           rxd_b = v;
  endtask

  task automatic send_bit(input int line, input logic v);
    drive_line(line, v);
    wait_ticks(16);
  endtask

  task automatic send_frame(input int line, input logic [7:0] d, input logic has_par,
                            input logic par, input logic stop1, input logic stop2,
                            input logic two_stop);
    send_bit(line, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(line, d[i]);
      if (i == 0) mid_rxrdy = (line == 0) ? rxrdy_a : rxrdy_b;
    end
    if (has_par) send_bit(line, par);
    send_bit(line, stop1);
    if (two_stop) send_bit(line, stop2);
  endtask

  initial begin
    rst   = 1'b1;
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    mid_rxrdy = 1'b1;
    ifa.RX_READY = 1'b1;
    ifb.RX_READY = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_valid", ifa.RX_VALID, 1'b0);
    chk8("rst_data", ifa.RX_DATA, 8'h00);
    chk1("rst_ferr", ifa.FRAME_ERROR, 1'b0);
    chk1("rst_perr", ifa.PARITY_ERROR, 1'b0);
    chk1("rst_ovr", ifa.OVERRUN, 1'b0);
    chk1("rst_rxrdy", rxrdy_a, 1'b1);
    chk1("rst_rxrdy_b", rxrdy_b, 1'b1);
    rst = 1'b0;
    wait_ticks(4);

    // 8N1 0xA5 with RX_READY held high
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_ticks(2);
    chk1("a5_busy", mid_rxrdy, 1'b0);
    chki("a5_pulses", vcnt_a, 1);
    chk1("a5_valid_low", ifa.RX_VALID, 1'b0);
    chk8("a5_data", ifa.RX_DATA, 8'hA5);
    chk1("a5_ferr", ifa.FRAME_ERROR, 1'b0);
    chk1("a5_perr", ifa.PARITY_ERROR, 1'b0);
    chk1("a5_ovr", ifa.OVERRUN, 1'b0);
    chk1("a5_rxrdy", rxrdy_a, 1'b1);

    // Even parity: 0x03 with wrong parity bit, then correct
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_ticks(2);
    chki("p_bad_pulses", vcnt_b, 1);
    chk8("p_bad_data", ifb.RX_DATA, 8'h03);
    chk1("p_bad_perr", ifb.PARITY_ERROR, 1'b1);
    chk1("p_bad_ferr", ifb.FRAME_ERROR, 1'b0);
    send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_ticks(2);
    chki("p_ok_pulses", vcnt_b, 2);
    chk8("p_ok_data", ifb.RX_DATA, 8'h03);
    chk1("p_ok_perr", ifb.PARITY_ERROR, 1'b0);

    // Second stop bit low, then line held low for three frame times
    send_frame(1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drive_line(1, 1'b0);
    wait_ticks(3 * 12 * 16);
    chki("brk_pulses", vcnt_b, 3);
    chk8("brk_data", ifb.RX_DATA, 8'h5A);
    chk1("brk_ferr", ifb.FRAME_ERROR, 1'b1);
    chk1("brk_perr", ifb.PARITY_ERROR, 1'b0);
    chk1("brk_rxrdy", rxrdy_b, 1'b1);
    drive_line(1, 1'b1);
    wait_ticks(16);
    send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_ticks(2);
    chki("post_brk_pulses", vcnt_b, 4);
    chk8("post_brk_data", ifb.RX_DATA, 8'h3C);
    chk1("post_brk_ferr", ifb.FRAME_ERROR, 1'b0);

    // Overrun: two frames with RX_READY low
    ifa.RX_READY = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk1("ovr1_valid", ifa.RX_VALID, 1'b1);
    chk8("ovr1_data", ifa.RX_DATA, 8'h11);
    chk1("ovr1_ovr", ifa.OVERRUN, 1'b0);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk1("ovr2_valid", ifa.RX_VALID, 1'b1);
    chk8("ovr2_data", ifa.RX_DATA, 8'h11);
    chk1("ovr2_ovr", ifa.OVERRUN, 1'b1);
    ifa.RX_READY = 1'b1;
    @(posedge clk);
    #1;
    ifa.RX_READY = 1'b0;
    chk1("acc_valid", ifa.RX_VALID, 1'b0);
    chk1("acc_ovr", ifa.OVERRUN, 1'b0);
    ifa.RX_READY = 1'b1;

    // Four-tick low glitch is a false start
    wait_ticks(4);
    base = vcnt_a;
    drive_line(0, 1'b0);
    wait_ticks(4);
    drive_line(0, 1'b1);
    wait_ticks(32);
    chki("glitch_pulses", vcnt_a, base);
    chk1("glitch_rxrdy", rxrdy_a, 1'b1);
    send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_ticks(2);
    chki("7e_pulses", vcnt_a, base + 1);
    chk8("7e_data", ifa.RX_DATA, 8'h7E);
    chk1("7e_ferr", ifa.FRAME_ERROR, 1'b0);

    // Reset in the middle of 0xFF data bits
    base = vcnt_a;
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    wait_ticks(8);
    chk1("pre_rst_busy", rxrdy_a, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk1("mrst_valid", ifa.RX_VALID, 1'b0);
    chk8("mrst_data", ifa.RX_DATA, 8'h00);
    chk1("mrst_ferr", ifa.FRAME_ERROR, 1'b0);
    chk1("mrst_perr", ifa.PARITY_ERROR, 1'b0);
    chk1("mrst_ovr", ifa.OVERRUN, 1'b0);
    chk1("mrst_rxrdy", rxrdy_a, 1'b1);
    rst = 1'b0;
    wait_ticks(48);
    chki("mrst_no_word", vcnt_a, base);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_ticks(2);
    chki("81_pulses", vcnt_a, base + 1);
    chk8("81_data", ifa.RX_DATA, 8'h81);
    chk1("81_ferr", ifa.FRAME_ERROR, 1'b0);
    chk1("81_rxrdy", rxrdy_a, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
